proc_mem_io: RTL

//  Memory/IO subsystem directly downstream of the 9-bit processor: consumes ADDR, Dout and W.

---
 rtl/proc_io_pkg.sv | 46 ++++
 rtl/hex_scan_driver.sv | 71 +++++++
 rtl/proc_mem_io.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/proc_io_pkg.sv
// Shared types and helpers for the processor memory/IO slice: region codes,
// scan-digit states and the active-low seven-segment decoder.
package proc_io_pkg;

  localparam int WORD_W = 9;
  localparam int HEX_W  = 4;

  typedef enum logic [1:0] {
    RGN_RAM = 2'd0,
    RGN_LED = 2'd1,
    RGN_HEX = 2'd2,
    RGN_SW  = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_scan_driver.sv
// Time-multiplexed seven-segment driver: a free-running refresh counter steps
// a digit FSM on every wrap; anode enables and segments are registered from it.
module hex_scan_driver
  import proc_io_pkg::*;
#(
  parameter int N_HEX     = 4,
  parameter int SCAN_BITS = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_HEX*HEX_W-1:0] digits,
  output logic [6:0]             hex_seg,
  output logic [N_HEX-1:0]       hex_an
);

  localparam logic [N_HEX-1:0] AN_RST = ~(N_HEX'(1));

  logic [SCAN_BITS-1:0] scan_cnt_reg;
  logic                 scan_wrap;
  digit_e               state_reg, state_next;
  logic [N_HEX-1:0]     an_reg, an_next;
  logic [6:0]           seg_reg, seg_next;
  logic [HEX_W-1:0]     digit_arr [4];

  // Pad to four entries so the 2-bit state can index the array directly.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    if (gi < N_HEX) begin : g_used
      assign digit_arr[gi] = digits[gi*HEX_W +: HEX_W];
    end else begin : g_pad
      assign digit_arr[gi] = '0;
    end
  end

  assign scan_wrap = &scan_cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt_reg <= '0;
      state_reg    <= DIG0;
      an_reg       <= AN_RST;
      seg_reg      <= seg7(4'h0);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
      state_reg    <= state_next;
      an_reg       <= an_next;
      seg_reg      <= seg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    an_next    = '1;
    seg_next   = seg7(digit_arr[state_reg]);
    if (scan_wrap) begin
      if (int'(state_reg) >= N_HEX - 1) begin
        state_next = DIG0;
      end else begin
        state_next = digit_e'(state_reg + 2'd1);
      end
    end
    for (int i = 0; i < N_HEX; i++) begin
      if (int'(state_reg) == i) begin
        an_next[i] = 1'b0;
      end
    end
  end

  assign hex_seg = seg_reg;
  assign hex_an  = an_reg;

endmodule

// File: rtl/proc_mem_io.sv
// Memory/IO subsystem behind the 9-bit processor: data RAM, LED and hex-digit
// registers, synchronised switches and a 1-cycle registered read path.
// Optional sticky bus-error flag: define PROC_MEM_IO_BUS_ERR_EN.
module proc_mem_io
  import proc_io_pkg::*;
#(
  parameter int RAM_AW    = 7,
  parameter int N_HEX     = 4,
  parameter int SCAN_BITS = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WORD_W-1:0] ADDR,
  input  logic [WORD_W-1:0] Dout,
  input  logic              W,
  input  logic [WORD_W-1:0] SW,
  output logic [WORD_W-1:0] Din,
  output logic [WORD_W-1:0] LEDR,
  output logic [6:0]        HEX_SEG,
  output logic [N_HEX-1:0]  HEX_AN,
  output logic              BUS_ERR
);

  localparam int RAM_DEPTH = 2**RAM_AW;

  region_e                  region;
  logic [1:0]               hex_idx;
  logic                     ram_we;
  logic                     led_we;
  logic [N_HEX-1:0]         hex_we;
  logic [N_HEX*HEX_W-1:0]   hex_flat;

  logic [WORD_W-1:0]        ram_mem [RAM_DEPTH];
  logic [WORD_W-1:0]        ram_q_reg;
  logic [WORD_W-1:0]        led_reg;
  logic [WORD_W-1:0]        sw_meta_reg, sw_sync_reg;
  logic [WORD_W-1:0]        rd_other_next, rd_other_reg;
  region_e                  rgn_q_reg;

  assign region  = region_e'(ADDR[8:7]);
  assign hex_idx = ADDR[1:0];
  assign ram_we  = W && (region == RGN_RAM);
  assign led_we  = W && (region == RGN_LED);

  // Block RAM: no reset, registered read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ADDR[RAM_AW-1:0]] <= Dout;
    end
    ram_q_reg <= ram_mem[ADDR[RAM_AW-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_reg     <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      if (led_we) begin
        led_reg <= Dout;
      end
      sw_meta_reg <= SW;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // Digits beyond N_HEX have no register, so writes there fall away.
  for (genvar gi = 0; gi < N_HEX; gi++) begin : g_hex
    logic [HEX_W-1:0] digit_reg;

    assign hex_we[gi] = W && (region == RGN_HEX) && (int'(hex_idx) == gi);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        digit_reg <= '0;
      end else if (hex_we[gi]) begin
        digit_reg <= Dout[HEX_W-1:0];
      end
    end

    assign hex_flat[gi*HEX_W +: HEX_W] = digit_reg;
  end

  always_comb begin
    rd_other_next = '0;
    case (region)
      RGN_LED: rd_other_next = led_reg;
      RGN_HEX: begin
        for (int i = 0; i < N_HEX; i++) begin
          if (int'(hex_idx) == i) begin
            rd_other_next = WORD_W'(hex_flat[i*HEX_W +: HEX_W]);
          end
        end
      end
      RGN_SW:  rd_other_next = sw_sync_reg;
      default: rd_other_next = '0;
    endcase
  end

  // Region is remembered so the RAM output register can bypass the mux stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_other_reg <= '0;
      rgn_q_reg    <= RGN_LED;
    end else begin
      rd_other_reg <= rd_other_next;
      rgn_q_reg    <= region;
    end
  end

  assign Din  = (rgn_q_reg == RGN_RAM) ? ram_q_reg : rd_other_reg;
  assign LEDR = led_reg;

`ifdef PROC_MEM_IO_BUS_ERR_EN
  logic hex_valid;
  logic bus_err_reg;

  assign hex_valid = (int'(hex_idx) < N_HEX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err_reg <= 1'b0;
    end else if (W && ((region == RGN_SW) || ((region == RGN_HEX) && !hex_valid))) begin
      bus_err_reg <= 1'b1;
    end
  end

  assign BUS_ERR = bus_err_reg;
`else
  assign BUS_ERR = 1'b0;
`endif

  hex_scan_driver #(
    .N_HEX    (N_HEX),
    .SCAN_BITS(SCAN_BITS)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .digits (hex_flat),
    .hex_seg(HEX_SEG),
    .hex_an (HEX_AN)
  );

endmodule
